imem_uart_loader: RTL
=====================

Name: imem_uart_loader

Overview:
Boot-time controller that fills the 256-word instruction memory from a UART byte stream and sequences CPU start-up.
- Decodes a framed download: sync byte, word count, big-endian words, XOR checksum.
- Drives the instruction memory write port.
- Holds the CPU in reset until a frame has been accepted without error.
- Sits between the UART receiver and the instruction memory/CPU reset tree.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
MEM_WORDS, 256, instruction memory depth in words; word index is Address[9:2].
TIMEOUT_CYCLES, 1000000, maximum idle clocks between bytes inside a frame.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
rx_data  in  8  byte from UART receiver
rx_valid  in  1  one-cycle strobe, rx_data valid
mem_we  out  1  instruction memory write enable, one-cycle pulse
mem_addr  out  32  byte address of write, always word aligned (bits[1:0]=0)
mem_wdata  out  32  instruction word to write
cpu_hold  out  1  held high to keep the CPU in reset
busy  out  1  frame in progress (state not IDLE)
load_done  out  1  one-cycle pulse on successful frame
load_err  out  1  sticky error flag

Behaviour:
- Reset (async, high): state=IDLE; mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, busy=0, load_done=0, load_err=0; word index, byte index, checksum and timer all cleared.
- Reset mid-frame aborts the frame. Words already written stay in memory. cpu_hold returns to 1.
- States:
  - IDLE: rx_valid with rx_data==SYNC_BYTE -> COUNT, cpu_hold=1, load_err=0, checksum=0. Any other byte is ignored.
  - COUNT: next byte is N. N=0 means MEM_WORDS words; otherwise N words. Latch the remaining-word count, clear the word index, go to DATA.
  - DATA: bytes arrive MSB first. The 4th byte of a word is at cycle t. At t+1: mem_we=1, mem_wdata={b0,b1,b2,b3}, mem_addr={22'd0, word_index, 2'b00}. Word index then increments. After the last word -> CHECK. Checksum = XOR of every data byte.
  - CHECK: the next byte is compared to the checksum.
    - Match: at t+1, load_done=1 for one cycle and cpu_hold=0; state -> IDLE.
    - Mismatch: load_err=1, cpu_hold stays 1, state -> IDLE.
- Timeout:
  - The timer counts clocks while in COUNT, DATA or CHECK and clears on every rx_valid.
  - When it reaches TIMEOUT_CYCLES: load_err=1, state -> IDLE, cpu_hold stays 1.
- A sync byte arriving in COUNT, DATA or CHECK is treated as data, not as a restart.
- mem_we is never asserted outside DATA. At most one write per 4 received bytes.
- Word index wraps only through N=0 (exactly MEM_WORDS writes, indices 0..255). It never exceeds MEM_WORDS-1.
- rx_valid in the same cycle as a timeout expiry: the byte wins and the timer clears.
- After a successful load, a new sync byte re-enters COUNT and reasserts cpu_hold. This gives a warm re-download.
- busy = (state != IDLE).
- Outputs are registered; there is no combinational path from rx_* to any output.

Decomposition:
- Shared package holds:
  - state enum {IDLE, COUNT, DATA, CHECK}
  - SYNC_BYTE default
  - IMEM_ADDR_LSB=2 and IMEM_ADDR_MSB=9 constants, shared with the instruction memory and PC logic.
- One natural sub-module: imem_word_assembler. It takes the byte shift register, byte counter and running XOR. It outputs word_ready, word and checksum. The FSM and timer stay in the top.

Test Plan:
- Frame A5,02,08,04,00,05,00,00,10,26,chk=0x3F -> writes 0x08040005 @0x0 and 0x00001026 @0x4, each mem_we one cycle after its 4th byte; load_done pulse; cpu_hold falls 1->0.
- Same frame with checksum 0x00 -> both writes occur; load_err=1, cpu_hold remains 1, no load_done.
- Bytes 00,FF,5A in IDLE, then a valid 1-word frame -> no writes before the sync byte; one write @0x0; load_done.
- Stall TIMEOUT_CYCLES after the 2nd data byte -> load_err=1, busy=0, no write issued, cpu_hold=1.
- Assert reset after 6 data bytes of a 2-word frame -> all outputs return to reset values next clock; a following full frame loads correctly from address 0.
- N=0 frame with 1024 data bytes -> 256 writes, last at mem_addr=0x3FC; checksum accepted; load_done.

Source files
------------

// File: rtl/imem_uart_loader_pkg.sv
// Shared boot-loader definitions: FSM states, frame constants and the
// instruction-memory word field, also used by the imem and PC logic.
package imem_uart_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DATA  = 2'd2,
        CHECK = 2'd3
    } state_e;

    localparam logic [7:0] SYNC_BYTE      = 8'hA5;
    localparam int         MEM_WORDS      = 256;
    localparam int         TIMEOUT_CYCLES = 1000000;
    localparam int         IMEM_ADDR_LSB  = 2;
    localparam int         IMEM_ADDR_MSB  = 9;

    function automatic logic [31:0] word_addr(input logic [IMEM_ADDR_MSB-IMEM_ADDR_LSB:0] idx);
        logic [31:0] a;
        a = '0;
        a[IMEM_ADDR_MSB:IMEM_ADDR_LSB] = idx;
        return a;
    endfunction

endpackage

// File: rtl/imem_uart_loader_word_assembler.sv
// Packs big-endian data bytes into 32-bit words and keeps the running XOR
// of every data byte in the current frame.
module imem_word_assembler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_ready_o,
    output logic [31:0] word_o,
    output logic [7:0]  checksum_o
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  xor_q, xor_d;

    // The fourth byte completes the word in the same cycle it arrives.
    assign word_ready_o = byte_valid_i && (cnt_q == 2'd3);
    assign word_o       = {shift_q, byte_i};
    assign checksum_o   = xor_q;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        xor_d   = xor_q;
        if (clear_i) begin
            shift_d = '0;
            cnt_d   = '0;
            xor_d   = '0;
        end else if (byte_valid_i) begin
            shift_d = {shift_q[15:0], byte_i};
            cnt_d   = cnt_q + 2'd1;
            xor_d   = xor_q ^ byte_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
            xor_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            xor_q   <= xor_d;
        end
    end

endmodule

// File: rtl/imem_uart_loader.sv
// UART frame loader: fills instruction memory and releases the CPU hold once
// a frame (sync, count, words, XOR checksum) is accepted.
//   state | meaning
//   IDLE  | waiting for sync byte
//   COUNT | next byte is the word count (0 = full memory)
//   DATA  | receiving big-endian words, one write per 4 bytes
//   CHECK | next byte is compared against the running XOR
module imem_uart_loader
    import imem_uart_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC             = SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYCLES_P = TIMEOUT_CYCLES
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        cpu_hold_o,
    output logic        busy_o,
    output logic        load_done_o,
    output logic        load_err_o
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES_P + 1);

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [7:0]           word_idx_q, word_idx_d;
    logic [8:0]           remain_q, remain_d;
    logic                 mem_we_q, mem_we_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [31:0]          mem_wdata_q, mem_wdata_d;
    logic                 cpu_hold_q, cpu_hold_d;
    logic                 load_done_q, load_done_d;
    logic                 load_err_q, load_err_d;

    logic        frame_start, data_byte, timeout;
    logic        word_ready;
    logic [31:0] word;
    logic [7:0]  checksum;

    assign frame_start = (state_q == IDLE) && rx_valid_i && (rx_data_i == SYNC);
    assign data_byte   = (state_q == DATA) && rx_valid_i;
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign timeout     = (state_q != IDLE) && !rx_valid_i && (timer_q == '0);

    imem_word_assembler u_asm (
        .clk_i        (clk_i),
        .rst_i        (reset_i),
        .clear_i      (frame_start),
        .byte_valid_i (data_byte),
        .byte_i       (rx_data_i),
        .word_ready_o (word_ready),
        .word_o       (word),
        .checksum_o   (checksum)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start) state_d = COUNT;
            COUNT:   if (rx_valid_i) state_d = DATA;
                     else if (timeout) state_d = IDLE;
            DATA:    if (timeout) state_d = IDLE;
                     else if (word_ready && remain_q == 9'd1) state_d = CHECK;
            CHECK:   if (rx_valid_i || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        load_done_d = 1'b0;
        load_err_d  = load_err_q;
        word_idx_d  = word_idx_q;
        remain_d    = remain_q;
        if (rx_valid_i)
            timer_d = TIMER_W'(TIMEOUT_CYCLES_P - 1);
        else if (state_q != IDLE && timer_q != '0)
            timer_d = timer_q - 1'b1;
        else
            timer_d = timer_q;

        case (state_q)
            IDLE: if (frame_start) begin
                cpu_hold_d = 1'b1;
                load_err_d = 1'b0;
            end
            COUNT: if (rx_valid_i) begin
                remain_d   = (rx_data_i == 8'd0) ? 9'(MEM_WORDS) : {1'b0, rx_data_i};
                word_idx_d = '0;
            end
            DATA: if (word_ready) begin
                mem_we_d    = 1'b1;
                mem_wdata_d = word;
                mem_addr_d  = word_addr(word_idx_q);
                word_idx_d  = word_idx_q + 8'd1;
                remain_d    = remain_q - 9'd1;
            end
            CHECK: if (rx_valid_i) begin
                if (rx_data_i == checksum) begin
                    load_done_d = 1'b1;
                    cpu_hold_d  = 1'b0;
                end else begin
                    load_err_d  = 1'b1;
                end
            end
            default: ;
        endcase

        if (timeout) load_err_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            timer_q     <= '0;
            word_idx_q  <= '0;
            remain_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            word_idx_q  <= word_idx_d;
            remain_q    <= remain_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign cpu_hold_o  = cpu_hold_q;
    assign busy_o      = (state_q != IDLE);
    assign load_done_o = load_done_q;
    assign load_err_o  = load_err_q;

endmodule
